// File: rtl/multi_cycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control_if
// Brief    : Control-unit <-> datapath/memory signal bundle.
// Revision : 1.0
// ============================================================================
interface multi_cycle_control_if;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic        IFetch;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        Reg2Loc;
  logic        ALUSrc;
  logic        MemToReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  ALUOp;
  logic [2:0]  State;
  logic        Illegal;
  logic        Timeout;

  // master = control unit, slave = datapath/memory side
  modport master (
    input  Opcode, Zero, MemReady,
    output IFetch, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemToReg,
           RegWrite, MemRead, MemWrite, ALUOp, State, Illegal, Timeout
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  IFetch, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemToReg,
           RegWrite, MemRead, MemWrite, ALUOp, State, Illegal, Timeout
  );
endinterface
`default_nettype wire

// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control
// Brief    : LEGv8 multi-cycle control FSM with memory handshake and traps.
// Revision : 1.0
// ============================================================================
module multi_cycle_control #(
  parameter bit          ENABLE_CBNZ = 1'b1,
  parameter bit          ENABLE_IMM  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  Reset_L,
  multi_cycle_control_if.master bus
);

  localparam logic [2:0] C_ST_FETCH  = 3'd0;
  localparam logic [2:0] C_ST_DECODE = 3'd1;
  localparam logic [2:0] C_ST_EXEC   = 3'd2;
  localparam logic [2:0] C_ST_MEM    = 3'd3;
  localparam logic [2:0] C_ST_WB     = 3'd4;
  localparam logic [2:0] C_ST_TRAP   = 3'd5;

  localparam logic [2:0] C_CL_RTYPE = 3'd0;
  localparam logic [2:0] C_CL_IMM   = 3'd1;
  localparam logic [2:0] C_CL_LOAD  = 3'd2;
  localparam logic [2:0] C_CL_STORE = 3'd3;
  localparam logic [2:0] C_CL_CBZ   = 3'd4;
  localparam logic [2:0] C_CL_CBNZ  = 3'd5;
  localparam logic [2:0] C_CL_B     = 3'd6;

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  logic [2:0] state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;

  logic [2:0] dec_class;
  logic       dec_legal;
  logic       mem_wait;

  logic       ifetch, irwrite, pcwrite, pcsrc;
  logic       reg2loc, alusrc, memtoreg, regwrite, memread, memwrite;
  logic [1:0] aluop;

  // Instruction decode; disabled optional opcodes keep their class but are illegal
  always_comb begin
    dec_class = C_CL_RTYPE;
    dec_legal = 1'b0;
    casez (bus.Opcode)
      11'b11111000010: begin dec_class = C_CL_LOAD;  dec_legal = 1'b1; end
      11'b11111000000: begin dec_class = C_CL_STORE; dec_legal = 1'b1; end
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: begin dec_class = C_CL_RTYPE; dec_legal = 1'b1; end
      11'b10110100???: begin dec_class = C_CL_CBZ;   dec_legal = 1'b1; end
      11'b10110101???: begin dec_class = C_CL_CBNZ;  dec_legal = ENABLE_CBNZ; end
      11'b000101?????: begin dec_class = C_CL_B;     dec_legal = 1'b1; end
      11'b1001000100?,
      11'b1101000100?: begin dec_class = C_CL_IMM;   dec_legal = ENABLE_IMM; end
      default:         begin dec_class = C_CL_RTYPE; dec_legal = 1'b0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    mem_wait  = 1'b0;

    case (state_q)
      C_ST_FETCH: begin
        if (bus.MemReady) state_d = C_ST_DECODE;
        else              mem_wait = 1'b1;
      end
      C_ST_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_class;
          state_d = C_ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = C_ST_TRAP;
        end
      end
      C_ST_EXEC: begin
        case (cls_q)
          C_CL_RTYPE, C_CL_IMM:  state_d = C_ST_WB;
          C_CL_LOAD, C_CL_STORE: state_d = C_ST_MEM;
          default:               state_d = C_ST_FETCH;
        endcase
      end
      C_ST_MEM: begin
        if (bus.MemReady) state_d = (cls_q == C_CL_LOAD) ? C_ST_WB : C_ST_FETCH;
        else              mem_wait = 1'b1;
      end
      C_ST_WB:   state_d = C_ST_FETCH;
      C_ST_TRAP: state_d = C_ST_TRAP;
      default:   state_d = C_ST_FETCH;
    endcase

    // A ready strobe on the limit cycle completes normally since mem_wait is then low
    if (mem_wait) begin
      if (cnt_q >= C_TIMEOUT) begin
        timeout_d = 1'b1;
        state_d   = C_ST_TRAP;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (state_d != state_q) cnt_d = 8'd0;
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q   <= C_ST_FETCH;
      cls_q     <= C_CL_RTYPE;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    ifetch   = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    aluop    = 2'b00;

    case (state_q)
      C_ST_FETCH: begin
        ifetch  = 1'b1;
        irwrite = bus.MemReady;
        pcwrite = bus.MemReady;
      end
      C_ST_DECODE: begin
        // Register read happens here, so Reg2Loc follows the live opcode
        reg2loc = dec_legal && ((dec_class == C_CL_STORE) || (dec_class == C_CL_CBZ) ||
                                (dec_class == C_CL_CBNZ));
      end
      C_ST_EXEC: begin
        case (cls_q)
          C_CL_RTYPE: aluop = 2'b10;
          C_CL_IMM: begin
            alusrc = 1'b1;
            aluop  = 2'b11;
          end
          C_CL_LOAD, C_CL_STORE: alusrc = 1'b1;
          C_CL_CBZ: begin
            reg2loc = 1'b1;
            aluop   = 2'b01;
            pcwrite = bus.Zero;
            pcsrc   = bus.Zero;
          end
          C_CL_CBNZ: begin
            reg2loc = 1'b1;
            aluop   = 2'b01;
            pcwrite = !bus.Zero;
            pcsrc   = !bus.Zero;
          end
          C_CL_B: begin
            pcwrite = 1'b1;
            pcsrc   = 1'b1;
          end
          default: ;
        endcase
      end
      C_ST_MEM: begin
        alusrc   = 1'b1;
        memread  = (cls_q == C_CL_LOAD);
        memwrite = (cls_q == C_CL_STORE);
        reg2loc  = (cls_q == C_CL_STORE);
      end
      C_ST_WB: begin
        regwrite = 1'b1;
        memtoreg = (cls_q == C_CL_LOAD);
      end
      default: ;
    endcase
  end

  assign bus.IFetch   = ifetch;
  assign bus.IRWrite  = irwrite;
  assign bus.PCWrite  = pcwrite;
  assign bus.PCSrc    = pcsrc;
  assign bus.Reg2Loc  = reg2loc;
  assign bus.ALUSrc   = alusrc;
  assign bus.MemToReg = memtoreg;
  assign bus.RegWrite = regwrite;
  assign bus.MemRead  = memread;
  assign bus.MemWrite = memwrite;
  assign bus.ALUOp    = aluop;
  assign bus.State    = state_q;
  assign bus.Illegal  = illegal_q;
  assign bus.Timeout  = timeout_q;

endmodule
`default_nettype wire
